// File: rtl/xbar_pkg.sv
// rtl/xbar_pkg.sv - shared crossbar constants and slave responder state type
package xbar_pkg;
   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   localparam logic [31:0] BAD_ADDR_DATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE,
      ACK_WAIT,
      RESP_WAIT
   } resp_state_t;
endpackage

// File: rtl/xbar_sp_ram.sv
// rtl/xbar_sp_ram.sv - single-port synchronous RAM, registered read, no reset
module xbar_sp_ram #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);
   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end
endmodule

// File: rtl/xbar_slave_responder.sv
// rtl/xbar_slave_responder.sv - memory-backed crossbar slave target with
// programmable ack/response latency and protocol violation counters
module xbar_slave_responder
   import xbar_pkg::*;
#(
   parameter int ADDR_W    = 30,
   parameter int MEM_DEPTH = 256,
   parameter int ACK_LAT   = 0,
   parameter int RESP_LAT  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              cmd,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              ack,
   output logic              resp,
   output logic [31:0]       rdata,
   output logic              busy,
   output logic [15:0]       drop_cnt,
   output logic [15:0]       err_cnt
);
   localparam int         IDX_W      = $clog2(MEM_DEPTH);
   localparam logic [3:0] ACK_LAT_C  = 4'(ACK_LAT);
   localparam logic [3:0] RESP_LAT_C = 4'(RESP_LAT);

   resp_state_t       state;
   logic [3:0]        cnt;
   logic              cmd_q;
   logic [IDX_W-1:0]  idx_q;
   logic              in_range_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rd_buf;

   logic [IDX_W-1:0]  ram_addr;
   logic              ram_we;
   logic [31:0]       ram_q;
   logic [31:0]       rd_word;
   logic              addr_in_range;

   assign addr_in_range = ((addr >> IDX_W) == '0);

   // The RAM reads every cycle at the pending index, so at the ack edge ram_q
   // already holds mem[index]; no write can land between capture and ack.
   assign ram_addr = (state == IDLE) ? addr[IDX_W-1:0] : idx_q;
   assign ram_we   = (state == ACK_WAIT) && ack && (cmd_q == CMD_WRITE) && in_range_q;
   assign rd_word  = in_range_q ? ram_q : BAD_ADDR_DATA;

   xbar_sp_ram #(
      .DEPTH (MEM_DEPTH),
      .AW    (IDX_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (wdata_q),
      .rdata (ram_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         ack        <= 1'b0;
         resp       <= 1'b0;
         rdata      <= '0;
         busy       <= 1'b0;
         drop_cnt   <= '0;
         err_cnt    <= '0;
         cmd_q      <= CMD_READ;
         idx_q      <= '0;
         in_range_q <= 1'b0;
         wdata_q    <= '0;
         rd_buf     <= '0;
      end else begin
         if (req && busy && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
         end

         case (state)
            IDLE: begin
               if (req) begin
                  cmd_q      <= cmd;
                  idx_q      <= addr[IDX_W-1:0];
                  in_range_q <= addr_in_range;
                  wdata_q    <= wdata;
                  cnt        <= ACK_LAT_C;
                  busy       <= 1'b1;
                  ack        <= (ACK_LAT_C == 4'd0);
                  state      <= ACK_WAIT;
               end
            end

            ACK_WAIT: begin
               if (ack) begin
                  ack <= 1'b0;
                  if (!in_range_q && (err_cnt != 16'hFFFF)) begin
                     err_cnt <= err_cnt + 16'd1;
                  end
                  if (cmd_q == CMD_WRITE) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     rd_buf <= rd_word;
                     cnt    <= RESP_LAT_C;
                     state  <= RESP_WAIT;
                     if (RESP_LAT_C == 4'd0) begin
                        resp  <= 1'b1;
                        rdata <= rd_word;
                     end
                  end
               end else if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
                  if (cnt == 4'd1) begin
                     ack <= 1'b1;
                  end
               end
            end

            RESP_WAIT: begin
               if (resp) begin
                  resp  <= 1'b0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
                  if (cnt == 4'd1) begin
                     resp  <= 1'b1;
                     rdata <= rd_buf;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end
endmodule
